// File: rtl/amba_axi_pkg.sv
// AXI4 channel bundles shared by initiators in this codebase.
// The request bundle carries AR, R-ready, AW, W and B-ready.
// The response bundle carries AR/AW/W-ready, R and B.
package amba_axi_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef struct packed {
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              rready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [2:0]        awprot;
    logic              awvalid;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              bready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              awready;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
  } s_axi_miso_t;

endpackage

// File: rtl/axi_custom_master_dma.sv
// Word-by-word memory copy engine acting as an AXI4 initiator.
// Each word is one single-beat read followed by one single-beat write;
// only one transaction is ever in flight. Any error response ends the
// copy early and leaves the sticky error flag set until the next start.
//
// Handshake rule on every channel: a transfer happens on a rising edge
// where VALID and READY are both high. VALID is a function of state
// registers only (never of READY on the same channel), and once raised
// it stays high with stable payload until the transfer happens.
module axi_custom_master_dma
  import amba_axi_pkg::*;
#(
  parameter logic [ID_W-1:0] AXI_ID      = '0,
  parameter int              MAX_WORDS_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output s_axi_mosi_t            axi_mosi,
  input  s_axi_miso_t            axi_miso,
  input  logic                   start,
  input  logic [31:0]            src_addr,
  input  logic [31:0]            dst_addr,
  input  logic [MAX_WORDS_W-1:0] num_words,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            src_q, dst_q, data_q;
  logic [MAX_WORDS_W-1:0] remaining_q;
  logic                   aw_done_q, w_done_q, error_q;

  // Fields the copy engine has no use for (IDs echo ours, every beat is last).
  logic unused_inputs;
  assign unused_inputs = ^{axi_miso.rid, axi_miso.rlast, axi_miso.bid,
                           src_addr[1:0], dst_addr[1:0]};

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign error     = error_q;
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and AXI request outputs; VALIDs come from state and the
  // per-channel done flags only.
  always_comb begin
    state_d          = state_q;
    axi_mosi         = '0;
    axi_mosi.arid    = AXI_ID;
    axi_mosi.araddr  = src_q;
    axi_mosi.arsize  = 3'b010;
    axi_mosi.arburst = BURST_INCR;
    axi_mosi.awid    = AXI_ID;
    axi_mosi.awaddr  = dst_q;
    axi_mosi.awsize  = 3'b010;
    axi_mosi.awburst = BURST_INCR;
    axi_mosi.wdata   = data_q;
    axi_mosi.wstrb   = 4'hF;
    axi_mosi.wlast   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (num_words != '0) ? ST_RD_ADDR : ST_DONE;
      end
      ST_RD_ADDR: begin
        axi_mosi.arvalid = 1'b1;
        if (axi_miso.arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        axi_mosi.rready = 1'b1;
        if (axi_miso.rvalid)
          state_d = (axi_miso.rresp != RESP_OKAY) ? ST_DONE : ST_WR_REQ;
      end
      ST_WR_REQ: begin
        axi_mosi.awvalid = !aw_done_q;
        axi_mosi.wvalid  = !w_done_q;
        if ((aw_done_q || axi_miso.awready) && (w_done_q || axi_miso.wready))
          state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        axi_mosi.bready = 1'b1;
        if (axi_miso.bvalid) begin
          if (axi_miso.bresp != RESP_OKAY)               state_d = ST_DONE;
          else if (remaining_q == MAX_WORDS_W'(1))       state_d = ST_DONE;
          else                                           state_d = ST_RD_ADDR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Copy datapath: addresses, word count, holding register, write-side
  // handshake flags and the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q       <= {src_addr[31:2], 2'b00};
            dst_q       <= {dst_addr[31:2], 2'b00};
            remaining_q <= num_words;
            error_q     <= 1'b0;
          end
        end
        ST_RD_DATA: begin
          if (axi_miso.rvalid) begin
            data_q <= axi_miso.rdata;
            if (axi_miso.rresp != RESP_OKAY) error_q <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (axi_mosi.awvalid && axi_miso.awready) aw_done_q <= 1'b1;
          if (axi_mosi.wvalid && axi_miso.wready)   w_done_q  <= 1'b1;
        end
        ST_WR_RESP: begin
          if (axi_miso.bvalid) begin
            if (axi_miso.bresp != RESP_OKAY) begin
              error_q <= 1'b1;
            end else begin
              // 32-bit adders wrap naturally past the top of the address map.
              src_q       <= src_q + 32'd4;
              dst_q       <= dst_q + 32'd4;
              remaining_q <= remaining_q - MAX_WORDS_W'(1);
            end
          end
        end
        default: ;
      endcase
      if (state_q != ST_WR_REQ) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_custom_master_dma.sv
// Bench for axi_custom_master_dma: a responsive AXI slave with per-channel
// delays and injectable error responses, a copy-level reference model that
// predicts the list of (address, data) writes, and a scoreboard.
module tb_axi_custom_master_dma;
  import amba_axi_pkg::*;

  localparam int              MW    = 16;
  localparam logic [ID_W-1:0] TB_ID = 4'h5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  s_axi_mosi_t     axi_mosi;
  s_axi_miso_t     axi_miso;
  logic            start;
  logic [31:0]     src_addr, dst_addr;
  logic [MW-1:0]   num_words;
  logic            busy, done, error;
  logic [2:0]      dbg_state;

  axi_custom_master_dma #(.AXI_ID(TB_ID), .MAX_WORDS_W(MW)) dut (
    .clk(clk), .rst(rst), .axi_mosi(axi_mosi), .axi_miso(axi_miso),
    .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .num_words(num_words),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // ---------------- slave configuration ----------------
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  int          r_err, b_err;          // per-copy word index that errors, -1 = none
  logic [31:0] seed;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // ---------------- slave state ----------------
  int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int          rd_idx, b_idx, viol;
  logic        r_pend, aw_got, w_got, b_pend;
  logic        ar_pend_q, aw_pend_q, w_pend_q;
  logic [31:0] rd_addr_q, wr_addr_q, wr_data_q;
  logic [31:0] ar_prev, aw_prev, w_prev;
  logic [63:0] obs_q[$];
  logic        aw_hs, w_hs, aw_now, w_now;
  logic [31:0] wa_n, wd_n;

  // Slave responses depend on slave registers only.
  always_comb begin
    axi_miso         = '0;
    axi_miso.arready = (ar_wait >= ar_dly);
    axi_miso.rvalid  = r_pend && (r_wait >= r_dly);
    axi_miso.rdata   = mem_word(rd_addr_q);
    axi_miso.rresp   = (rd_idx == r_err) ? RESP_SLVERR : RESP_OKAY;
    axi_miso.rlast   = 1'b1;
    axi_miso.rid     = TB_ID;
    axi_miso.awready = (aw_wait >= aw_dly);
    axi_miso.wready  = (w_wait >= w_dly);
    axi_miso.bvalid  = b_pend && (b_wait >= b_dly);
    axi_miso.bresp   = (b_idx == b_err) ? RESP_SLVERR : RESP_OKAY;
    axi_miso.bid     = TB_ID;
  end

  // Slave sequencing, protocol checks and write capture.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_wait <= 0; r_wait <= 0; aw_wait <= 0; w_wait <= 0; b_wait <= 0;
      rd_idx <= 0; b_idx <= 0;
      r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      ar_pend_q <= 1'b0; aw_pend_q <= 1'b0; w_pend_q <= 1'b0;
      rd_addr_q <= '0; wr_addr_q <= '0; wr_data_q <= '0;
    end else begin
      if (start && !busy) begin
        rd_idx <= 0;
        b_idx  <= 0;
      end
      // AR
      if (axi_mosi.arvalid) begin
        if (axi_miso.arready) begin
          ar_wait <= 0; r_pend <= 1'b1; r_wait <= 0; rd_addr_q <= axi_mosi.araddr;
          if (axi_mosi.arlen != 8'd0 || axi_mosi.arsize != 3'b010 ||
              axi_mosi.arburst != BURST_INCR || axi_mosi.arid != TB_ID ||
              axi_mosi.araddr[1:0] != 2'b00 || r_pend || aw_got || w_got || b_pend)
            viol <= viol + 1;
        end else ar_wait <= ar_wait + 1;
      end
      // R
      if (r_pend) begin
        if (axi_miso.rvalid && axi_mosi.rready) begin
          r_pend <= 1'b0;
          rd_idx <= rd_idx + 1;
        end else if (!axi_miso.rvalid) r_wait <= r_wait + 1;
      end
      // AW / W
      aw_hs = axi_mosi.awvalid && axi_miso.awready;
      w_hs  = axi_mosi.wvalid && axi_miso.wready;
      if (axi_mosi.awvalid && !axi_miso.awready) aw_wait <= aw_wait + 1;
      if (axi_mosi.wvalid && !axi_miso.wready)   w_wait  <= w_wait + 1;
      if (aw_hs) begin
        aw_wait <= 0;
        if (axi_mosi.awlen != 8'd0 || axi_mosi.awsize != 3'b010 ||
            axi_mosi.awburst != BURST_INCR || axi_mosi.awid != TB_ID ||
            axi_mosi.awaddr[1:0] != 2'b00 || aw_got || b_pend)
          viol <= viol + 1;
      end
      if (w_hs) begin
        w_wait <= 0;
        if (axi_mosi.wstrb != 4'hF || !axi_mosi.wlast || w_got || b_pend)
          viol <= viol + 1;
      end
      aw_now = aw_got || aw_hs;
      w_now  = w_got || w_hs;
      wa_n   = aw_hs ? axi_mosi.awaddr : wr_addr_q;
      wd_n   = w_hs ? axi_mosi.wdata : wr_data_q;
      wr_addr_q <= wa_n;
      wr_data_q <= wd_n;
      if (aw_now && w_now) begin
        b_pend <= 1'b1; b_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
      // B
      if (b_pend) begin
        if (axi_miso.bvalid && axi_mosi.bready) begin
          b_pend <= 1'b0;
          b_idx  <= b_idx + 1;
          obs_q.push_back({wr_addr_q, wr_data_q});
        end else if (!axi_miso.bvalid) b_wait <= b_wait + 1;
      end
      // VALID must hold with stable payload until accepted
      if (ar_pend_q && (!axi_mosi.arvalid || axi_mosi.araddr != ar_prev)) viol <= viol + 1;
      if (aw_pend_q && (!axi_mosi.awvalid || axi_mosi.awaddr != aw_prev)) viol <= viol + 1;
      if (w_pend_q && (!axi_mosi.wvalid || axi_mosi.wdata != w_prev))     viol <= viol + 1;
      ar_pend_q <= axi_mosi.arvalid && !axi_miso.arready;
      aw_pend_q <= axi_mosi.awvalid && !axi_miso.awready;
      w_pend_q  <= axi_mosi.wvalid && !axi_miso.wready;
      ar_prev   <= axi_mosi.araddr;
      aw_prev   <= axi_mosi.awaddr;
      w_prev    <= axi_mosi.wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the copy as a list of writes, stopping at the first
  // failing read (no write) or failing write response (write still issued).
  task automatic model(input logic [31:0] s, input logic [31:0] d, input int n,
                       input int re, input int be, output logic e);
    logic [31:0] sa, da;
    exp_q.delete();
    e  = 1'b0;
    sa = s & ~32'h3;
    da = d & ~32'h3;
    for (int i = 0; i < n; i++) begin
      if (i == re) begin e = 1'b1; break; end
      exp_q.push_back({da + 32'(4 * i), mem_word(sa + 32'(4 * i))});
      if (i == be) begin e = 1'b1; break; end
    end
  endtask

  // ---------------- driver ----------------
  int done_idx, ar_idx, done_cnt, aw_hi, w_hi;

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n, input bit poke);
    int k;
    done_idx = -1; ar_idx = -1; done_cnt = 0; aw_hi = 0; w_hi = 0;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; num_words = MW'(n);
    @(negedge clk);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; num_words = MW'($urandom);
    k = 1;
    while (done_idx < 0 && k < 500) begin
      if (axi_mosi.arvalid && ar_idx < 0) ar_idx = k;
      aw_hi += int'(axi_mosi.awvalid);
      w_hi  += int'(axi_mosi.wvalid);
      if (done) begin done_cnt++; done_idx = k; end
      if (poke && k == 3) begin
        start = 1'b1; src_addr = 32'hDEAD_0000; dst_addr = 32'hBEEF_0000; num_words = MW'(7);
      end else start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    repeat (2) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] src, dst;
    int          n, r_err, b_err, ar_d, r_d, aw_d, w_d, b_d;
    logic        exp_err;
    int          exp_writes;
    int          exp_lat;     // cycles from start to done pulse, -1 = not checked
    bit          aw_chk;      // AWREADY-late shape check
  } vec_t;

  task automatic do_copy(input string tag, input vec_t v, input bit use_model, input bit poke);
    logic me;
    int   base, v0, ne;
    ar_dly = v.ar_d; r_dly = v.r_d; aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d;
    r_err = v.r_err; b_err = v.b_err;
    seed = $urandom;
    model(v.src, v.dst, v.n, v.r_err, v.b_err, me);
    if (use_model) begin
      v.exp_err    = me;
      v.exp_writes = exp_q.size();
      v.exp_lat    = (v.ar_d + v.r_d + v.aw_d + v.w_d + v.b_d == 0 && !me) ? 4 * v.n + 1 : -1;
    end
    base = obs_q.size();
    v0   = viol;
    run_copy(v.src, v.dst, v.n, poke);
    check({tag, " finished"}, 64'(done_idx >= 0), 64'd1);
    check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " error"}, 64'(error), 64'(v.exp_err));
    check({tag, " busy after"}, 64'(busy), 64'd0);
    check({tag, " protocol"}, 64'(viol - v0), 64'd0);
    check({tag, " write count"}, 64'(obs_q.size() - base), 64'(v.exp_writes));
    ne = (obs_q.size() - base < exp_q.size()) ? obs_q.size() - base : exp_q.size();
    for (int i = 0; i < ne; i++) check({tag, " write addr/data"}, obs_q[base + i], exp_q[i]);
    if (v.exp_lat >= 0) begin
      check({tag, " latency"}, 64'(done_idx), 64'(v.exp_lat));
      if (v.n > 0) check({tag, " first AR to done"}, 64'(done_idx - ar_idx), 64'(4 * v.n));
      else         check({tag, " no AR"}, 64'(ar_idx), 64'hFFFF_FFFF_FFFF_FFFF);
    end
    if (v.aw_chk) begin
      check({tag, " awvalid cycles"}, 64'(aw_hi), 64'd4);
      check({tag, " wvalid cycles"}, 64'(w_hi), 64'd1);
    end
  endtask

  vec_t tbl[10];
  vec_t rv;

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    start = 1'b0; src_addr = '0; dst_addr = '0; num_words = '0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    r_err = -1; b_err = -1; seed = 32'h1;
    viol = 0;

    //          src            dst            n  rerr berr ar r  aw w  b  err wr lat  awchk
    tbl[0] = '{32'h0000_1000, 32'h0000_2000, 3, -1, -1, 0, 0, 0, 0, 0, 1'b0, 3, 13, 1'b0};
    tbl[1] = '{32'h1234_5670, 32'h0000_0000, 0, -1, -1, 0, 0, 0, 0, 0, 1'b0, 0,  1, 1'b0};
    tbl[2] = '{32'h0000_1100, 32'h0000_2100, 1, -1, -1, 0, 0, 3, 0, 0, 1'b0, 1, -1, 1'b1};
    tbl[3] = '{32'h0000_3000, 32'h0000_3800, 3,  1, -1, 0, 0, 0, 0, 0, 1'b1, 1, -1, 1'b0};
    tbl[4] = '{32'h0000_4000, 32'h0000_4800, 2, -1, -1, 0, 0, 0, 0, 0, 1'b0, 2,  9, 1'b0};
    tbl[5] = '{32'hFFFF_FFFC, 32'h0000_5000, 2, -1, -1, 0, 0, 0, 0, 0, 1'b0, 2,  9, 1'b0};
    tbl[6] = '{32'h0000_6002, 32'hFFFF_FFF8, 4, -1, -1, 1, 2, 0, 1, 3, 1'b0, 4, -1, 1'b0};
    tbl[7] = '{32'h0000_7000, 32'h0000_7800, 3, -1,  1, 0, 0, 0, 0, 0, 1'b1, 2, -1, 1'b0};
    tbl[8] = '{32'h0000_8000, 32'h0000_8800, 2, -1, -1, 2, 0, 1, 2, 1, 1'b0, 2, -1, 1'b0};
    tbl[9] = '{32'h0000_9000, 32'h0000_9800, 3, -1, -1, 0, 0, 0, 0, 0, 1'b0, 3, 13, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset error", 64'(error), 64'd0);
    check("reset valids/readies",
          64'({axi_mosi.arvalid, axi_mosi.rready, axi_mosi.awvalid, axi_mosi.wvalid, axi_mosi.bready}),
          64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors (entry 9 pokes start while busy)
    for (int i = 0; i < 9; i++) do_copy($sformatf("vec%0d", i), tbl[i], 1'b0, 1'b0);
    do_copy("start-while-busy", tbl[9], 1'b0, 1'b1);

    // Reset while in the write request phase
    aw_dly = 8; w_dly = 0; ar_dly = 0; r_dly = 0; b_dly = 0; r_err = -1; b_err = -1;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h0000_A000; dst_addr = 32'h0000_B000; num_words = MW'(2);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!axi_mosi.awvalid && cnt < 50) begin @(negedge clk); cnt++; end
    check("reached write request", 64'(axi_mosi.awvalid), 64'd1);
    rst = 1'b0;
    #1;
    check("mid-reset valids",
          64'({axi_mosi.arvalid, axi_mosi.awvalid, axi_mosi.wvalid, axi_mosi.rready, axi_mosi.bready}),
          64'd0);
    check("mid-reset busy", 64'(busy), 64'd0);
    check("mid-reset done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle after reset busy", 64'(busy), 64'd0);
    check("idle after reset arvalid", 64'(axi_mosi.arvalid), 64'd0);
    rv = '{32'h0000_C000, 32'h0000_D000, 1, -1, -1, 0, 0, 0, 0, 0, 1'b0, 1, 5, 1'b0};
    do_copy("after-reset", rv, 1'b0, 1'b0);

    // Randomized copies checked against the model
    for (int t = 0; t < 25; t++) begin
      rv.src   = $urandom;
      rv.dst   = $urandom;
      rv.n     = $urandom_range(0, 6);
      rv.ar_d  = $urandom_range(0, 3);
      rv.r_d   = $urandom_range(0, 3);
      rv.aw_d  = $urandom_range(0, 3);
      rv.w_d   = $urandom_range(0, 3);
      rv.b_d   = $urandom_range(0, 3);
      if (t % 4 == 0) begin
        rv.ar_d = 0; rv.r_d = 0; rv.aw_d = 0; rv.w_d = 0; rv.b_d = 0;
      end
      rv.r_err  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1;
      rv.b_err  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1;
      rv.aw_chk = 1'b0;
      do_copy($sformatf("rand%0d", t), rv, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/axi_custom_master_dma.md
AXI_CUSTOM_MASTER_DMA -- requirements
Module: axi_custom_master_dma

Interface
REQ-001 SHALL import amba_axi_pkg and act as AXI4 initiator; data width 32 bits, address width per package.
REQ-002 Parameter: AXI_ID, default 0, ID driven on ARID/AWID.
REQ-003 Parameter: MAX_WORDS_W, default 16, width of the transfer length.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 axi_mosi  output  s_axi_mosi_t  AXI request channels (AR, R-ready, AW, W, B-ready).
REQ-007 axi_miso  input  s_axi_miso_t  AXI response channels (AR/AW/W-ready, R, B).
REQ-008 start  input  1  one-cycle request to begin a copy.
REQ-009 src_addr  input  32  source byte address; bits [1:0] forced to 0.
REQ-010 dst_addr  input  32  destination byte address; bits [1:0] forced to 0.
REQ-011 num_words  input  MAX_WORDS_W  number of 32-bit words to copy.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse at end of copy (normal or aborted).
REQ-014 error  output  1  sticky; set on any non-OKAY RRESP/BRESP; cleared by next accepted start.

Function
REQ-015 Every transaction SHALL be single-beat: LEN=0, SIZE=3'b010, BURST=INCR, WSTRB=4'hF, WLAST=1; other mosi fields 0.
REQ-016 FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-017 IDLE: start=1 SHALL latch src/dst/num_words, clear error; next state RD_ADDR if num_words!=0, else DONE.
REQ-018 start while not IDLE SHALL be ignored with no effect on latched values.
REQ-019 RD_ADDR: ARVALID=1, ARADDR=current src; ARVALID/ARADDR stable until ARREADY; on handshake -> RD_DATA.
REQ-020 RD_DATA: RREADY=1; on RVALID capture RDATA into 32-bit holding register; RRESP!=OKAY -> set error, go DONE; else -> WR_REQ.
REQ-021 WR_REQ: AWVALID=1 and WVALID=1 asserted in same cycle; each dropped independently after its own handshake; leave to WR_RESP once both handshakes done (same or different cycles).
REQ-022 WR_RESP: BREADY=1; on BVALID: BRESP!=OKAY -> set error, go DONE; else increment src and dst by 4, decrement remaining count; remaining==0 -> DONE, else RD_ADDR.
REQ-023 Address increment SHALL wrap modulo 2^32 without error.
REQ-024 DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
REQ-025 At most one outstanding transaction; no new AR before prior B received.
REQ-026 Minimum per-word latency with zero-wait slave: 4 cycles (RD_ADDR, RD_DATA, WR_REQ, WR_RESP).
REQ-027 VALID signals SHALL never depend combinationally on READY of the same channel.

Reset
REQ-028 rst low SHALL asynchronously force state IDLE, all VALID/READY outputs 0, busy=0, done=0, error=0, counters/addresses/data register 0.
REQ-029 Reset mid-transfer SHALL abandon transfer immediately; after release block idles until next start.

Verification
REQ-030 start, src=0x1000, dst=0x2000, num_words=3, zero-wait slave -> reads 0x1000/0x1004/0x1008, writes same data to 0x2000/0x2004/0x2008, done pulse one cycle, error=0, 12 cycles from first ARVALID to DONE.
REQ-031 num_words=0 -> no AXI activity, busy one cycle, done pulse the cycle after start.
REQ-032 AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles with stable AWADDR, single B accepted, copy correct.
REQ-033 Second word returns RRESP=SLVERR -> no write of word 2, error=1, done pulse, IDLE; next start clears error.
REQ-034 src=0xFFFFFFFC, num_words=2 -> second read at 0x00000000, no error.
REQ-035 rst asserted while in WR_REQ -> all VALIDs 0 same cycle, busy=0; start after release with num_words=1 completes normally.
